// File: rtl/univ_shift_reg.sv
// Universal shift register: manual shift/rotate/load operations in IDLE, plus an
// autonomous serialising burst (IDLE -> SHIFT -> DONE) launched by start.
module univ_shift_reg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             ser_in,
   input  logic [WIDTH-1:0] par_in,
   input  logic             start,
   input  logic             dir,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_SHR  = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_ROR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_LOAD = 3'b101
   } mode_t;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] rem_q, rem_d;

   logic [WIDTH-1:0] shr_v, shl_v, ror_v, rol_v;
   mode_t            mode_s;

   assign mode_s = mode_t'(mode);

   always_comb begin
      shr_v = {ser_in, q_q[WIDTH-1:1]};
      shl_v = {q_q[WIDTH-2:0], ser_in};
      ror_v = {q_q[0], q_q[WIDTH-1:1]};
      rol_v = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      unique case (state_q)
         IDLE: begin
            // start wins over any manual operation requested in the same cycle
            if (start) begin
               q_d     = par_in;
               dir_d   = dir;
               rem_d   = (count == '0) ? FULL_CNT : count;
               state_d = SHIFT;
            end else if (en) begin
               case (mode_s)
                  MODE_SHR: begin
                     q_d   = shr_v;
                     dir_d = 1'b0;
                  end
                  MODE_SHL: begin
                     q_d   = shl_v;
                     dir_d = 1'b1;
                  end
                  MODE_ROR: begin
                     q_d   = ror_v;
                     dir_d = 1'b0;
                  end
                  MODE_ROL: begin
                     q_d   = rol_v;
                     dir_d = 1'b1;
                  end
                  MODE_LOAD: q_d = par_in;
                  default:   q_d = q_q;
               endcase
            end
         end
         SHIFT: begin
            q_d   = dir_q ? shl_v : shr_v;
            rem_d = rem_q - ONE_CNT;
            if (rem_q <= ONE_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         dir_q   <= 1'b0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
      end
   end

   // Outputs decode registered state only; serial_out taps the current leading bit.
   assign q          = q_q;
   assign serial_out = dir_q ? q_q[WIDTH-1] : q_q[0];
   assign busy       = (state_q == SHIFT);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): manual modes, bursts, start/en
// interaction and asynchronous reset in mid-burst.
module tb_univ_shift_reg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             en;
   logic [2:0]       mode;
   logic             ser_in;
   logic [WIDTH-1:0] par_in;
   logic             start;
   logic             dir;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] q;
   logic             serial_out;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   univ_shift_reg #(
      .WIDTH(WIDTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .mode      (mode),
      .ser_in    (ser_in),
      .par_in    (par_in),
      .start     (start),
      .dir       (dir),
      .count     (count),
      .q         (q),
      .serial_out(serial_out),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launches a burst and checks each serial bit, burst length, done pulse and final q.
   task automatic burst(input string tag, input logic [7:0] pdata, input logic d,
                        input logic [3:0] cnt, input logic s, input int exp_len,
                        input logic [7:0] exp_q);
      int   n;
      logic exp_bit;
      @(negedge clk);
      par_in = pdata;
      dir    = d;
      count  = cnt;
      ser_in = s;
      en     = 1'b0;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         exp_bit = (n < 8) ? (d ? pdata[7-n] : pdata[n]) : s;
         chk({tag, " serial_bit"}, 32'(serial_out), 32'(exp_bit));
         n++;
         @(negedge clk);
      end
      chk({tag, " busy_len"}, n, exp_len);
      chk({tag, " done"}, 32'(done), 1);
      chk({tag, " busy_end"}, 32'(busy), 0);
      chk({tag, " q_final"}, 32'(q), 32'(exp_q));
      @(negedge clk);
      chk({tag, " done_clear"}, 32'(done), 0);
      chk({tag, " q_hold"}, 32'(q), 32'(exp_q));
   endtask

   logic [7:0] exp_sr [4] = '{8'h80, 8'hC0, 8'hE0, 8'hF0};
   int         n;

   initial begin
      en     = 1'b0;
      mode   = 3'b000;
      ser_in = 1'b0;
      par_in = '0;
      start  = 1'b0;
      dir    = 1'b0;
      count  = '0;

      #1 reset = 1'b1;
      #1;
      chk("rst q", 32'(q), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst serial_out", 32'(serial_out), 0);

      // Release reset and request an operation for the very first edge.
      @(negedge clk);
      reset  = 1'b0;
      en     = 1'b1;
      mode   = 3'b001;
      ser_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("shr fill", 32'(q), 32'(exp_sr[i]));
      end
      chk("shr serial_out", 32'(serial_out), 0);

      mode   = 3'b010;
      ser_in = 1'b0;
      @(negedge clk);
      chk("shl q", 32'(q), 32'hE0);
      chk("shl serial_out msb", 32'(serial_out), 1);

      mode = 3'b110;
      @(negedge clk);
      chk("mode110 hold", 32'(q), 32'hE0);

      mode   = 3'b101;
      par_in = 8'h81;
      @(negedge clk);
      chk("load 81", 32'(q), 32'h81);
      mode = 3'b011;
      @(negedge clk);
      chk("ror", 32'(q), 32'hC0);
      mode = 3'b100;
      @(negedge clk);
      chk("rol", 32'(q), 32'h81);
      en   = 1'b0;
      mode = 3'b011;
      @(negedge clk);
      @(negedge clk);
      chk("en0 hold", 32'(q), 32'h81);

      burst("burst_r8", 8'hA5, 1'b0, 4'd0, 1'b0, 8, 8'h00);
      burst("burst_l3", 8'hA5, 1'b1, 4'd3, 1'b1, 3, 8'h2F);
      burst("burst_r10", 8'hA5, 1'b0, 4'd10, 1'b1, 10, 8'hFF);

      // start held through a whole burst must not lengthen or repeat it
      @(negedge clk);
      par_in = 8'h0F;
      dir    = 1'b0;
      count  = 4'd3;
      ser_in = 1'b0;
      start  = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy === 1'b1) n++;
         if (done === 1'b1) break;
      end
      start = 1'b0;
      chk("restart len", n, 3);
      chk("restart done", 32'(done), 1);
      chk("restart q", 32'(q), 32'h01);
      @(negedge clk);
      chk("restart idle", 32'(busy), 0);

      @(negedge clk);
      par_in = 8'h3C;
      count  = 4'd1;
      dir    = 1'b0;
      ser_in = 1'b1;
      en     = 1'b1;
      mode   = 3'b101;
      start  = 1'b1;
      @(negedge clk);
      chk("prio busy", 32'(busy), 1);
      chk("prio q load", 32'(q), 32'h3C);
      start  = 1'b0;
      par_in = 8'h55;
      @(negedge clk);
      chk("prio done", 32'(done), 1);
      chk("prio q shifted", 32'(q), 32'h9E);
      en = 1'b0;
      @(negedge clk);
      chk("prio q hold", 32'(q), 32'h9E);
      chk("prio idle", 32'(busy), 0);

      @(negedge clk);
      par_in = 8'hA5;
      dir    = 1'b0;
      count  = 4'd0;
      ser_in = 1'b0;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid busy before", 32'(busy), 1);
      chk("rst_mid q before", 32'(q), 32'h0A);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid q", 32'(q), 0);
      chk("rst_mid busy", 32'(busy), 0);
      chk("rst_mid done", 32'(done), 0);
      chk("rst_mid serial_out", 32'(serial_out), 0);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) n++;
      end
      chk("rst_mid no activity", n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range WIDTH >= 2.
REQ-002 SHALL have derived parameter CNT_W, default $clog2(WIDTH+1), width of the burst counter and of `count`.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, enable for manual mode operations.
REQ-006 SHALL have port mode, input, 3 bits, manual operation select.
REQ-007 SHALL have port ser_in, input, 1 bit, serial fill bit for shifts.
REQ-008 SHALL have port par_in, input, WIDTH bits, parallel load data.
REQ-009 SHALL have port start, input, 1 bit, burst request; level is sampled each cycle.
REQ-010 SHALL have port dir, input, 1 bit, burst direction: 0 = right (LSB first), 1 = left (MSB first).
REQ-011 SHALL have port count, input, CNT_W bits, number of burst shifts; value 0 means WIDTH.
REQ-012 SHALL have port q, output, WIDTH bits, register contents.
REQ-013 SHALL have port serial_out, output, 1 bit, equal to dir_r ? q[WIDTH-1] : q[0].
REQ-014 SHALL have port busy, output, 1 bit, high while a burst is shifting.
REQ-015 SHALL have port done, output, 1 bit, one-cycle pulse on burst completion.

Function
REQ-016 SHALL implement the FSM states IDLE, SHIFT and DONE, with busy = (state == SHIFT) and done = (state == DONE).
REQ-017 SHALL, in IDLE with start=1, load q <= par_in, latch dir_r <= dir, set rem <= (count==0 ? WIDTH : count), and go to SHIFT.
REQ-018 SHALL give start priority over en/mode in the same cycle.
REQ-019 SHALL, in SHIFT each cycle, shift q one place in direction dir_r with ser_in filling the vacated end, and decrement rem.
REQ-020 SHALL, in SHIFT, go to DONE on the cycle where rem==1 performs its shift; SHIFT therefore lasts exactly rem cycles.
REQ-021 SHALL present bit k of the loaded word (k = 0..N-1, in burst order) on serial_out during SHIFT cycle k.
REQ-022 SHALL, in DONE, hold q, assert done for one cycle, and return to IDLE unconditionally.
REQ-023 SHALL ignore start, en and mode while in SHIFT or DONE, with no queuing of requests.
REQ-024 SHALL, in IDLE with start=0 and en=1, apply mode as follows:
- 000: hold
- 001: shift right, q <= {ser_in, q[W-1:1]}, dir_r <= 0
- 010: shift left, q <= {q[W-2:0], ser_in}, dir_r <= 1
- 011: rotate right, dir_r <= 0
- 100: rotate left, dir_r <= 1
- 101: parallel load from par_in, dir_r unchanged
- 110 and 111: hold
REQ-025 SHALL hold q and dir_r when en=0 in IDLE.
REQ-026 SHALL treat a count value greater than WIDTH as a burst of that many shifts; bits beyond WIDTH output the ser_in fill.
REQ-027 SHALL NOT drive any output through a combinational path from inputs, except that serial_out is combinational from q and dir_r only.

Reset
REQ-028 SHALL, on reset=1 at any time including mid-burst, immediately force q=0, dir_r=0, rem=0, state=IDLE, busy=0, done=0, serial_out=0.
REQ-029 SHALL, on reset deassertion, accept start or en from the first following rising edge.

Verification
REQ-030 SHALL verify, with WIDTH=8: par_in=8'hA5, dir=0, count=0, ser_in=0, start pulse -> busy high 8 cycles, serial_out 1,0,1,0,0,1,0,1, then done for 1 cycle, then q=8'h00.
REQ-031 SHALL verify: par_in=8'hA5, dir=1, count=3, ser_in=1, start pulse -> serial_out 1,0,1, busy 3 cycles, final q=8'h2F, done pulse.
REQ-032 SHALL verify: en=1 with mode=101 and par_in=8'h81 -> q=8'h81; then mode=011 -> q=8'hC0; then mode=100 -> q=8'h81; then en=0 with mode=011 -> q stays 8'h81.
REQ-033 SHALL verify: q=0, mode=001, ser_in=1, en=1 for 4 cycles -> q=8'hF0, serial_out=0.
REQ-034 SHALL verify: start asserted again mid-burst -> ignored, burst length unchanged; start and en with mode=101 in the same IDLE cycle -> burst starts, load from par_in occurs once.
REQ-035 SHALL verify: reset asserted in SHIFT cycle 4 of an 8-bit burst -> q=0, busy=0, done=0 without waiting for a clock edge, and no done pulse afterwards.
